// File: rtl/term_pkg.sv
// Shared terminal definitions: ASCII control codes, screen geometry defaults
// and the escape-parser state encoding used by the terminal blocks.
package term_pkg;

  localparam int COLS_DEF   = 80;
  localparam int ROWS_DEF   = 24;
  localparam int COL_W_DEF  = 7;
  localparam int ROW_W_DEF  = 5;
  localparam int ADDR_W_DEF = 11;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_SP       = 8'h20;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;

  typedef enum logic [1:0] {
    ST_GROUND,
    ST_ESC,
    ST_CSI,
    ST_CLEAR
  } term_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // CSI final bytes live in 0x40..0x7E.
  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/ansi_decoder_csi_param_acc.sv
// Two saturating decimal CSI parameter accumulators with index and digit-seen
// flags; the *_eff outputs apply the "missing or zero means 1" default.
module csi_param_acc
  import term_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       digit_v,
  input  logic [3:0] digit,
  input  logic       sep,
  output logic [7:0] p0_raw,
  output logic       p0_seen,
  output logic [7:0] p0_eff,
  output logic [7:0] p1_eff
);

  logic [7:0] p0_q, p0_d;
  logic [7:0] p1_q, p1_d;
  logic       idx_q, idx_d;
  logic       seen0_q, seen0_d;
  logic       seen1_q, seen1_d;

  // 255*10+9 fits in 12 bits, so the product never wraps before the clamp.
  function automatic logic [7:0] sat_acc(input logic [7:0] p, input logic [3:0] d);
    logic [11:0] t;
    t = ({4'b0, p} * 12'd10) + {8'b0, d};
    return (t > 12'd255) ? 8'd255 : t[7:0];
  endfunction

  always_comb begin
    p0_d    = p0_q;
    p1_d    = p1_q;
    idx_d   = idx_q;
    seen0_d = seen0_q;
    seen1_d = seen1_q;
    if (clr) begin
      p0_d    = '0;
      p1_d    = '0;
      idx_d   = 1'b0;
      seen0_d = 1'b0;
      seen1_d = 1'b0;
    end else if (digit_v) begin
      if (!idx_q) begin
        p0_d    = sat_acc(p0_q, digit);
        seen0_d = 1'b1;
      end else begin
        p1_d    = sat_acc(p1_q, digit);
        seen1_d = 1'b1;
      end
    end else if (sep) begin
      idx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q    <= '0;
      p1_q    <= '0;
      idx_q   <= 1'b0;
      seen0_q <= 1'b0;
      seen1_q <= 1'b0;
    end else begin
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      idx_q   <= idx_d;
      seen0_q <= seen0_d;
      seen1_q <= seen1_d;
    end
  end

  assign p0_raw  = p0_q;
  assign p0_seen = seen0_q;
  assign p0_eff  = (!seen0_q || (p0_q == 8'd0)) ? 8'd1 : p0_q;
  assign p1_eff  = (!seen1_q || (p1_q == 8'd0)) ? 8'd1 : p1_q;

endmodule

// File: rtl/ansi_decoder.sv
// Terminal byte-stream decoder: printable characters become screen-cell writes,
// CR/LF/BS and CSI sequences move the cursor, ESC[2J sweeps the screen with spaces.
module ansi_decoder
  import term_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_v,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ROW_W-1:0]  o_cur_row,
  output logic [COL_W-1:0]  o_cur_col
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

  // Handshake: a byte transfers on a rising edge where i_byte_v && o_ready;
  // the producer keeps i_byte stable and i_byte_v high until that edge.

  term_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic              accept;
  logic              acc_clr, acc_digit_v, acc_sep;
  logic [7:0]        p0_raw, p0_eff, p1_eff;
  logic              p0_seen;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_col, last_row;
  logic [ROW_W-1:0]  row_next;
  int                cur_r, cur_c, n0, n1;

  csi_param_acc u_params (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .digit_v (acc_digit_v),
    .digit   (i_byte[3:0]),
    .sep     (acc_sep),
    .p0_raw  (p0_raw),
    .p0_seen (p0_seen),
    .p0_eff  (p0_eff),
    .p1_eff  (p1_eff)
  );

  assign accept   = i_byte_v && ready_q;
  assign cur_addr = (ADDR_W'(row_q) * ADDR_W'(COLS)) + ADDR_W'(col_q);
  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign row_next = last_row ? '0 : row_q + ROW_W'(1);
  assign cur_r    = int'(row_q);
  assign cur_c    = int'(col_q);
  assign n0       = int'(p0_eff);
  assign n1       = int'(p1_eff);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    clr_addr_d  = clr_addr_q;
    acc_clr     = 1'b0;
    acc_digit_v = 1'b0;
    acc_sep     = 1'b0;

    case (state_q)
      ST_GROUND: begin
        if (accept) begin
          if (is_printable(i_byte)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = i_byte;
            if (last_col) begin
              col_d = '0;
              row_d = row_next;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (i_byte == ASCII_CR) begin
            col_d = '0;
          end else if (i_byte == ASCII_LF) begin
            row_d = row_next;
          end else if (i_byte == ASCII_BS) begin
            col_d = (col_q == '0) ? '0 : col_q - COL_W'(1);
          end else if (i_byte == ASCII_ESC) begin
            state_d = ST_ESC;
          end
        end
      end

      ST_ESC: begin
        if (accept) begin
          if (i_byte == ASCII_LBRACKET) begin
            state_d = ST_CSI;
            acc_clr = 1'b1;
          end else begin
            state_d = ST_GROUND;
          end
        end
      end

      ST_CSI: begin
        if (accept) begin
          if (is_digit(i_byte)) begin
            acc_digit_v = 1'b1;
          end else if (i_byte == ";") begin
            acc_sep = 1'b1;
          end else if (i_byte == ASCII_ESC) begin
            state_d = ST_ESC;
          end else if (is_final(i_byte)) begin
            state_d = ST_GROUND;
            case (i_byte)
              "H", "f": begin
                row_d = ROW_W'((n0 >= ROWS) ? ROWS - 1 : n0 - 1);
                col_d = COL_W'((n1 >= COLS) ? COLS - 1 : n1 - 1);
              end
              "A": row_d = ROW_W'((n0 >= cur_r) ? 0 : cur_r - n0);
              "B": row_d = ROW_W'((cur_r + n0 >= ROWS - 1) ? ROWS - 1 : cur_r + n0);
              "C": col_d = COL_W'((cur_c + n0 >= COLS - 1) ? COLS - 1 : cur_c + n0);
              "D": col_d = COL_W'((n0 >= cur_c) ? 0 : cur_c - n0);
              "J": begin
                // Only an explicit "2" clears; a defaulted parameter does not.
                if (p0_seen && (p0_raw == 8'd2)) begin
                  state_d    = ST_CLEAR;
                  clr_addr_d = '0;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = ASCII_SP;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_GROUND;
          row_d      = '0;
          col_d      = '0;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end

      default: state_d = ST_GROUND;
    endcase

    ready_d = (state_d != ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GROUND;
      row_q      <= '0;
      col_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ready_q    <= 1'b1;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ready_q    <= ready_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_cur_row = row_q;
  assign o_cur_col = col_q;

endmodule

// File: tb/tb_ansi_decoder.sv
// Bench for ansi_decoder: a cycle-level terminal model fed by accepted bytes is
// compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_ansi_decoder;

  localparam int COLS   = 80;
  localparam int ROWS   = 24;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = 11;
  localparam int CELLS  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        i_byte = 8'h00;
  logic              i_byte_v = 1'b0;
  logic              o_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;
  logic [ROW_W-1:0]  o_cur_row;
  logic [COL_W-1:0]  o_cur_col;

  always #5 clk = ~clk;

  ansi_decoder #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_byte    (i_byte),
    .i_byte_v  (i_byte_v),
    .o_ready   (o_ready),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_cur_row (o_cur_row),
    .o_cur_col (o_cur_col)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]          acc_q[$];  // bytes accepted at the last rising edge
  logic [ADDR_W+7:0]   exp_q[$];  // expected {addr, data} writes this cycle

  // Terminal model state (plain integers)
  int m_row, m_col, m_mode, m_p0, m_p1, m_seen0, m_seen1, m_idx;
  int clr_on, clr_k, low_run;
  int last_addr = -1;
  int last_data = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    m_row = 0; m_col = 0; m_mode = 0;
    m_p0 = 0; m_p1 = 0; m_seen0 = 0; m_seen1 = 0; m_idx = 0;
    clr_on = 0; clr_k = 0;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // mode: 0 ground, 1 after ESC, 2 inside CSI
  function automatic void model_apply(input int b);
    int n0, n1;
    if (m_mode == 0) begin
      if (b >= 32 && b <= 126) begin
        exp_q.push_back({ADDR_W'(m_row * COLS + m_col), 8'(b)});
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
        end
      end else if (b == 13) m_col = 0;
      else if (b == 10) m_row = (m_row + 1) % ROWS;
      else if (b == 8) m_col = max_i(m_col - 1, 0);
      else if (b == 27) m_mode = 1;
    end else if (m_mode == 1) begin
      if (b == 91) begin
        m_mode = 2; m_p0 = 0; m_p1 = 0; m_seen0 = 0; m_seen1 = 0; m_idx = 0;
      end else m_mode = 0;
    end else begin
      n0 = (m_p0 == 0) ? 1 : m_p0;
      n1 = (m_p1 == 0) ? 1 : m_p1;
      if (b >= 48 && b <= 57) begin
        if (m_idx == 0) begin m_p0 = min_i(m_p0 * 10 + b - 48, 255); m_seen0 = 1; end
        else begin m_p1 = min_i(m_p1 * 10 + b - 48, 255); m_seen1 = 1; end
      end else if (b == 59) m_idx = 1;
      else if (b == 27) m_mode = 1;
      else if (b >= 64 && b <= 126) begin
        m_mode = 0;
        if (b == 72 || b == 102) begin
          m_row = min_i(n0, ROWS) - 1;
          m_col = min_i(n1, COLS) - 1;
        end else if (b == 65) m_row = max_i(m_row - n0, 0);
        else if (b == 66) m_row = min_i(m_row + n0, ROWS - 1);
        else if (b == 67) m_col = min_i(m_col + n0, COLS - 1);
        else if (b == 68) m_col = max_i(m_col - n0, 0);
        else if (b == 74 && m_seen0 == 1 && m_p0 == 2) begin
          clr_on = 1; clr_k = 0;
        end
      end
    end
  endfunction

  // Compare process: runs on every falling edge.
  initial begin
    logic [ADDR_W+7:0] e;
    int exp_wr;
    model_reset();
    low_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        acc_q.delete();
        exp_q.delete();
        low_run = 0;
      end else begin
        if (acc_q.size() > 0) model_apply(int'(acc_q.pop_front()));
        else if (clr_on == 1) begin
          exp_q.push_back({ADDR_W'(clr_k), 8'h20});
          clr_k++;
          if (clr_k == CELLS) begin
            clr_on = 0; m_row = 0; m_col = 0;
          end
        end
        exp_wr = (exp_q.size() > 0) ? 1 : 0;
        check("wr_en", int'(o_wr_en), exp_wr);
        if (exp_wr == 1) begin
          e = exp_q.pop_front();
          if (o_wr_en) begin
            check("wr_addr", int'(o_wr_addr), int'(e[ADDR_W+7:8]));
            check("wr_data", int'(o_wr_data), int'(e[7:0]));
            last_addr = int'(o_wr_addr);
            last_data = int'(o_wr_data);
          end
        end
        check("ready", int'(o_ready), (clr_on == 1) ? 0 : 1);
        check("cur_row", int'(o_cur_row), m_row);
        check("cur_col", int'(o_cur_col), m_col);
        if (!o_ready) low_run++;
        else if (low_run > 0) begin
          check("clear_ready_low_cycles", low_run, 1920);
          low_run = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte   = b;
    i_byte_v = 1'b1;
    while (!o_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      n_checks++;
      $display("FAIL handshake_timeout: ready still %0d after %0d cycles, expected 1", o_ready, n);
      i_byte_v = 1'b0;
      return;
    end
    @(posedge clk);
    acc_q.push_back(b);
    #1 i_byte_v = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_csi(input string s);
    send_byte(8'h1B);
    send_str({"[", s});
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, int'(o_cur_row), r);
    check({name, "_col"}, int'(o_cur_col), c);
  endtask

  task automatic check_last_wr(input string name, input int a, input int d);
    check({name, "_addr"}, last_addr, a);
    check({name, "_data"}, last_data, d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("rst_ready", int'(o_ready), 1);
    check("rst_wr_en", int'(o_wr_en), 0);
    check("rst_wr_addr", int'(o_wr_addr), 0);
    check("rst_wr_data", int'(o_wr_data), 0);
    check_cursor("rst", 0, 0);

    send_byte("A");
    settle();
    check_last_wr("wr_A", 0, 65);
    send_byte("B");
    settle();
    check_last_wr("wr_B", 1, 66);
    check_cursor("after_AB", 0, 2);
    check("model_after_AB_col", m_col, 2);

    send_csi("5;10H");
    settle();
    check_cursor("cup_5_10", 4, 9);
    send_byte("x");
    settle();
    check_last_wr("wr_x", 329, 120);

    send_csi("24;80H");
    send_byte("z");
    settle();
    check_last_wr("wr_z_corner", 1919, 122);
    check_cursor("wrap_corner", 0, 0);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h08);
    settle();
    check_cursor("cr_lf_bs", 1, 0);

    send_csi("2J");
    send_byte("q");
    settle();
    check_last_wr("held_q", 0, 113);
    check_cursor("after_clear_q", 0, 1);
    check("model_after_clear_col", m_col, 1);

    send_csi("999;999H");
    settle();
    check_cursor("cup_sat", 23, 79);
    send_csi("3D");
    settle();
    check_cursor("cub_3", 23, 76);
    send_csi("0A");
    settle();
    check_cursor("cuu_0", 22, 76);
    send_csi("Q");
    settle();
    check_cursor("unknown_final", 22, 76);
    check("unknown_final_no_wr", int'(o_wr_en), 0);

    send_csi(";;5C");
    send_csi("B");
    send_csi("9B");
    send_byte(8'h1B);
    send_str("[3");
    send_csi("2D");
    send_byte(8'h1B);
    send_byte("x");
    send_byte(8'h07);
    send_csi("J");
    send_csi("5;3J");
    settle();
    check_cursor("misc_seq", 23, 75);
    check("misc_ready", int'(o_ready), 1);

    send_csi("2J");
    repeat (500) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("midclr_rst_ready", int'(o_ready), 1);
    check("midclr_rst_wr_en", int'(o_wr_en), 0);
    check_cursor("midclr_rst", 0, 0);
    send_byte("k");
    settle();
    check_last_wr("wr_k", 0, 107);
    check_cursor("after_k", 0, 1);

    repeat (5) settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
